// File: rtl/spi_pkg.sv
// Shared encodings for the SPI master: FSM states and the mode / bit-order constants.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_H0,
    ST_H1,
    ST_TRAIL
  } spi_state_e;

  localparam logic CPHA_LEAD  = 1'b0;
  localparam logic CPHA_TRAIL = 1'b1;
  localparam logic MSB_FIRST  = 1'b0;
  localparam logic LSB_FIRST  = 1'b1;

endpackage

// File: rtl/spi_half_tick.sv
// Half-period timer: reloads from the divider latched at frame start, pulses tick every div+1 cycles.
module spi_half_tick #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;

  always_comb begin
    // NOTE: defaults first, so every path assigns each _d and no latch is inferred.
    cnt_d = cnt_q;
    div_d = div_q;
    if (load) begin
      cnt_d = div;
      div_d = div;
    end else if (cnt_q == '0) begin
      cnt_d = div_q;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      div_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end

  assign tick = (cnt_q == '0);

endmodule

// File: rtl/spi_master_param.sv
// SPI master: DATA_W-bit full-duplex frames, run-time divider, CPOL/CPHA, bit order, held chip selects.
module spi_master_param
  import spi_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NUM_CS = 4,
  parameter int DIV_W  = 8,
  localparam int CS_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              cs_hold,
  input  logic              cs_release,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              ready,
  output logic              done,
  output logic              err,
  output logic              SCLK,
  output logic              MOSI,
  input  logic              MISO,
  output logic [NUM_CS-1:0] CS_N
);
  localparam int BC_W = $clog2(DATA_W);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_W - 1);
  localparam logic [CS_W:0]   NUM_CS_L = (CS_W + 1)'(NUM_CS);

  function automatic logic head_bit(input logic [DATA_W-1:0] v, input logic lsb);
    return (lsb == LSB_FIRST) ? v[0] : v[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] v, input logic lsb);
    return (lsb == LSB_FIRST) ? {1'b0, v[DATA_W-1:1]} : {v[DATA_W-2:0], 1'b0};
  endfunction

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] v, input logic b,
                                                 input logic lsb);
    return (lsb == LSB_FIRST) ? {b, v[DATA_W-1:1]} : {v[DATA_W-2:0], b};
  endfunction

  function automatic logic [NUM_CS-1:0] cs_mask_n(input logic [CS_W-1:0] sel);
    logic [NUM_CS-1:0] m;
    m      = '1;
    m[sel] = 1'b0;
    return m;
  endfunction

  spi_state_e        state_q, state_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [NUM_CS-1:0] cs_n_q, cs_n_d;
  logic              mosi_q, mosi_d;
  logic              err_q, err_d;
  logic              cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d;
  logic              cs_hold_q, cs_hold_d, cfg_seen_q, cfg_seen_d;
  logic              accept, tick, sel_ok;

  assign sel_ok = ({1'b0, cs_sel} < NUM_CS_L);

  spi_half_tick #(.DIV_W(DIV_W)) u_half_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (accept),
    .div     (clk_div),
    .tick    (tick)
  );

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    cs_n_d     = cs_n_q;
    mosi_d     = mosi_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    lsb_d      = lsb_q;
    cs_hold_d  = cs_hold_q;
    cfg_seen_d = cfg_seen_q;
    err_d      = 1'b0;
    accept     = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start && sel_ok) begin
          accept     = 1'b1;
          state_d    = ST_LEAD;
          bit_cnt_d  = '0;
          cpol_d     = cpol;
          cpha_d     = cpha;
          lsb_d      = lsb_first;
          cs_hold_d  = cs_hold;
          cfg_seen_d = 1'b1;
          cs_n_d     = cs_mask_n(cs_sel);
          tx_sh_d    = tx_data;
          // With cpha=0 the first bit must already be on MOSI before the first SCLK edge.
          if (cpha == CPHA_LEAD) begin
            mosi_d  = head_bit(tx_data, lsb_first);
            tx_sh_d = shift_out(tx_data, lsb_first);
          end
        end else if (start) begin
          err_d = 1'b1;
        end else if (cs_release) begin
          cs_n_d = '1;
        end
      end
      ST_LEAD: if (tick) state_d = ST_H0;
      ST_H0: begin
        if (tick) begin
          state_d = ST_H1;
          if (cpha_q == CPHA_LEAD) begin
            rx_sh_d = shift_in(rx_sh_q, MISO, lsb_q);
          end else begin
            mosi_d  = head_bit(tx_sh_q, lsb_q);
            tx_sh_d = shift_out(tx_sh_q, lsb_q);
          end
        end
      end
      ST_H1: begin
        if (tick) begin
          if (cpha_q == CPHA_TRAIL) begin
            rx_sh_d = shift_in(rx_sh_q, MISO, lsb_q);
          end else if (bit_cnt_q != LAST_BIT) begin
            mosi_d  = head_bit(tx_sh_q, lsb_q);
            tx_sh_d = shift_out(tx_sh_q, lsb_q);
          end
          if (bit_cnt_q == LAST_BIT) begin
            state_d = ST_TRAIL;
          end else begin
            state_d   = ST_H0;
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      ST_TRAIL: begin
        if (tick) begin
          done      = 1'b1;
          rx_data_d = rx_sh_q;
          state_d   = ST_IDLE;
          if (!cs_hold_q) cs_n_d = '1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      cs_n_q     <= '1;
      mosi_q     <= 1'b0;
      err_q      <= 1'b0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      lsb_q      <= 1'b0;
      cs_hold_q  <= 1'b0;
      cfg_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      cs_n_q     <= cs_n_d;
      mosi_q     <= mosi_d;
      err_q      <= err_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      lsb_q      <= lsb_d;
      cs_hold_q  <= cs_hold_d;
      cfg_seen_q <= cfg_seen_d;
    end
  end

  assign ready   = (state_q == ST_IDLE);
  assign rx_data = done ? rx_sh_q : rx_data_q;
  assign MOSI    = mosi_q;
  assign err     = err_q;
  // Until the first frame latches a polarity, the idle clock follows the live cpol input.
  assign SCLK    = (state_q == ST_H1) ? ~cpol_q : (cfg_seen_q ? cpol_q : cpol);
  // Switching a held line to a different slave releases the old line during the start cycle.
  assign CS_N    = (accept && (cs_n_q != cs_n_d)) ? '1 : cs_n_q;

endmodule
